timer_ctrl: RTL and testbench
=============================

Name: timer_ctrl

Overview:
- Programmable interval-timer controller that sequences an up-counter datapath.
- Captures a terminal value and a prescale divisor on start, then advances the count once every (prescale+1) cycles.
- Signals a terminal event when the count reaches the terminal value, in one-shot or periodic mode.
- Supports pause, resume and abort.
- Sits between the control/register logic and the counter datapath; done feeds interrupt logic.

Parameters:
- WIDTH, 8, width of count and terminal value.
- PRE_W, 4, width of prescale divisor.

Ports:
- clk  input  1  system clock; all logic on posedge.
- rst  input  1  synchronous active-high reset.
- start  input  1  single-cycle request; begins a run from IDLE or DONE.
- stop  input  1  abort; returns to IDLE.
- pause  input  1  level; while high in RUN/PAUSED, counting is frozen.
- periodic  input  1  mode select: 1=periodic, 0=one-shot; sampled on accepted start.
- load_val  input  WIDTH  terminal value; sampled on accepted start.
- prescale  input  PRE_W  divisor minus one; sampled on accepted start.
- count  output  WIDTH  current count, registered.
- done  output  1  one-cycle registered pulse on terminal event.
- busy  output  1  high in RUN or PAUSED.
- err  output  1  one-cycle pulse when start is rejected because load_val==0.
- state  output  2  IDLE=0, RUN=1, PAUSED=2, DONE=3.

Behaviour:
- Reset (rst=1 at posedge): state=IDLE; count=0; prescale counter=0; shadow registers=0; done=0; err=0; busy=0. Reset overrides every other input.
- Priority, highest first: rst, stop, pause, terminal event, prescale advance.
- IDLE / DONE, start=1 with load_val!=0:
  - Capture load_val, prescale and periodic into shadow registers.
  - count<=0 and pre_cnt<=0.
  - Next state is RUN.
- IDLE / DONE, start=1 with load_val==0:
  - err<=1 for one cycle.
  - State and count are unchanged.
- DONE, stop=1: state<=IDLE and count<=0.
- stop=1 in IDLE: no effect.
- RUN, each cycle:
  - stop=1: state<=IDLE, count<=0, pre_cnt<=0, no done pulse.
  - Otherwise pause=1: state<=PAUSED; nothing advances that cycle.
  - Otherwise, when pre_cnt==prescale_sh: pre_cnt<=0 and a count step occurs. When pre_cnt!=prescale_sh: pre_cnt<=pre_cnt+1.
- Count step in RUN:
  - If count==load_sh-1, this is the terminal event:
    - done<=1 for one cycle.
    - Periodic mode: count<=0 and the state stays RUN.
    - One-shot mode: count<=load_sh and state<=DONE.
  - Otherwise count<=count+1.
- Step rate and timing:
  - Steps occur every prescale_sh+1 cycles.
  - The first step lands prescale_sh+1 edges after the start edge.
  - A full period is (load_sh)*(prescale_sh+1) cycles.
- PAUSED:
  - count and pre_cnt are held.
  - pause=0 returns to RUN with no lost or extra cycle.
  - stop=1 goes to IDLE with count=0.
- start in RUN or PAUSED is ignored; there is no recapture and no err.
- Input changes to load_val, prescale or periodic during a run have no effect until the next accepted start.
- load_val = 2^WIDTH-1 is legal. The count never wraps past the terminal value, so arithmetic stays within WIDTH bits with no overflow.
- load_val=1: a terminal event occurs on every step.
- busy is decoded from the registered state.
- done and err are never high in consecutive cycles unless the periodic terminal events themselves are consecutive (load=1, prescale=0).

Test Plan:
- Reset then one-shot: rst 2 cycles; start with load_val=3, prescale=0, periodic=0.
  - Required: count 1, 2 on the next two edges; on the third edge count=3, done=1 (one cycle), state=DONE, busy=0.
- Periodic with prescale: load_val=2, prescale=2, periodic=1.
  - Required: count steps every 3 cycles (0,1,0,1...); done pulses every 6 cycles; state stays RUN.
- Pause/resume: load=5, prescale=0; pause high 4 cycles after count=2.
  - Required: count holds at 2 and state=PAUSED for 4 cycles; after pause drops, done arrives exactly 4 cycles later than without the pause.
- Stop priority: assert stop in the same cycle as the terminal step (count=load-1).
  - Required: state=IDLE, count=0, done stays 0.
- Rejected and ignored starts:
  - start with load_val=0 in IDLE: err pulse, state stays IDLE.
  - start with load=9 mid-run: ignored; the run finishes at its original terminal value.
- Sync reset mid-run: rst=1 while in RUN with count=4.
  - Required: after that edge, count=0, state=IDLE, done=0, busy=0; an immediate restart works normally.

Source files
------------

// File: rtl/timer_ctrl_if.sv
// Control and status bundle between register logic and the interval timer.
// The register/control side holds the master modport, and the timer holds the slave modport.
interface timer_ctrl_if #(
    parameter int WIDTH = 8,
    parameter int PRE_W = 4
);
    logic             start;
    logic             stop;
    logic             pause;
    logic             periodic;
    logic [WIDTH-1:0] load_val;
    logic [PRE_W-1:0] prescale;
    logic [WIDTH-1:0] count;
    logic             done;
    logic             busy;
    logic             err;
    logic [1:0]       state;

    modport master (
        output start, stop, pause, periodic, load_val, prescale,
        input  count, done, busy, err, state
    );

    modport slave (
        input  start, stop, pause, periodic, load_val, prescale,
        output count, done, busy, err, state
    );
endinterface

// File: rtl/timer_ctrl.sv
// Programmable interval timer controller.
// A start request captures the terminal value, prescale divisor and mode.
// After that, the count advances once every (prescale+1) cycles.
// When the count reaches the terminal value, the controller raises a done pulse.
module timer_ctrl #(
    parameter int WIDTH = 8,
    parameter int PRE_W = 4
) (
    input  logic         clk,
    input  logic         rst,
    timer_ctrl_if.slave  bus
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        RUN    = 2'd1,
        PAUSED = 2'd2,
        DONE   = 2'd3
    } state_e;

    state_e           state_q;
    logic [WIDTH-1:0] count_q;
    logic [PRE_W-1:0] pre_cnt_q;
    logic [WIDTH-1:0] load_sh_q;
    logic [PRE_W-1:0] prescale_sh_q;
    logic             periodic_sh_q;
    logic             done_q;
    logic             err_q;

    logic             stepDue;
    logic             terminalStep;

    // Detect a prescale rollover and whether that step lands on the terminal value.
    // Because the count stops at load_sh, load_sh-1 never underflows while a run is active.
    always_comb begin
        stepDue      = (pre_cnt_q == prescale_sh_q);
        terminalStep = (count_q == (load_sh_q - WIDTH'(1)));
    end

    // Run the single controller FSM with registered count, pulse and shadow state.
    // A PAUSED cycle that releases pause also advances the count.
    // As a result, each cycle spent with pause high costs exactly one cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= IDLE;
            count_q       <= '0;
            pre_cnt_q     <= '0;
            load_sh_q     <= '0;
            prescale_sh_q <= '0;
            periodic_sh_q <= 1'b0;
            done_q        <= 1'b0;
            err_q         <= 1'b0;
        end else begin
            done_q <= 1'b0;
            err_q  <= 1'b0;
            case (state_q)
                IDLE, DONE: begin
                    if (bus.stop) begin
                        state_q <= IDLE;
                        count_q <= '0;
                    end else if (bus.start) begin
                        if (bus.load_val != '0) begin
                            load_sh_q     <= bus.load_val;
                            prescale_sh_q <= bus.prescale;
                            periodic_sh_q <= bus.periodic;
                            count_q       <= '0;
                            pre_cnt_q     <= '0;
                            state_q       <= RUN;
                        end else begin
                            err_q <= 1'b1;
                        end
                    end
                end
                RUN, PAUSED: begin
                    if (bus.stop) begin
                        state_q   <= IDLE;
                        count_q   <= '0;
                        pre_cnt_q <= '0;
                    end else if (bus.pause) begin
                        state_q <= PAUSED;
                    end else if (stepDue) begin
                        pre_cnt_q <= '0;
                        if (terminalStep) begin
                            done_q <= 1'b1;
                            if (periodic_sh_q) begin
                                count_q <= '0;
                                state_q <= RUN;
                            end else begin
                                count_q <= load_sh_q;
                                state_q <= DONE;
                            end
                        end else begin
                            count_q <= count_q + WIDTH'(1);
                            state_q <= RUN;
                        end
                    end else begin
                        pre_cnt_q <= pre_cnt_q + PRE_W'(1);
                        state_q   <= RUN;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign bus.count = count_q;
    assign bus.done  = done_q;
    assign bus.err   = err_q;
    assign bus.state = state_q;
    assign bus.busy  = (state_q == RUN) || (state_q == PAUSED);

endmodule

// File: tb/tb_timer_ctrl.sv
// Self-checking bench for timer_ctrl.
// Each scenario task pushes the expected post-edge status onto a scoreboard queue while driving inputs.
// After the edge, the task pops that entry and compares it against the DUT.
module tb_timer_ctrl;

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_RUN    = 2'd1;
    localparam logic [1:0] S_PAUSED = 2'd2;
    localparam logic [1:0] S_DONE   = 2'd3;

    typedef struct packed {
        logic [7:0] count;
        logic       done;
        logic       busy;
        logic       err;
        logic [1:0] state;
    } obs_t;

    logic clk;
    logic rst;
    int   checks;
    int   errors;
    obs_t sbq[$];
    obs_t got;
    obs_t want;

    timer_ctrl_if #(.WIDTH(8), .PRE_W(4)) bus ();

    timer_ctrl #(.WIDTH(8), .PRE_W(4)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // Free-running clock with a 10-unit period.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic obs_t mk(input logic [7:0] c, input logic d, input logic b,
                                input logic e, input logic [1:0] s);
        obs_t o;
        o.count = c;
        o.done  = d;
        o.busy  = b;
        o.err   = e;
        o.state = s;
        return o;
    endfunction

    function automatic obs_t sample();
        return mk(bus.count, bus.done, bus.busy, bus.err, bus.state);
    endfunction

    function automatic string fmt(input obs_t o);
        return $sformatf("count=%0d done=%0b busy=%0b err=%0b state=%0d",
                         o.count, o.done, o.busy, o.err, o.state);
    endfunction

    // Advance one edge and land 1 time unit after it, away from the active edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idleInputs();
        bus.start    = 1'b0;
        bus.stop     = 1'b0;
        bus.pause    = 1'b0;
        bus.periodic = 1'b0;
        bus.load_val = 8'd0;
        bus.prescale = 4'd0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        bus.start    = 1'b1;
        bus.load_val = 8'd5;
        for (int i = 0; i < 2; i++) begin
            sbq.push_back(mk(8'd0, 1'b0, 1'b0, 1'b0, S_IDLE));
            tick();
            got = sample(); want = sbq.pop_front(); checks++;
            if (got !== want) begin
                errors++;
                $display("[TB] FAIL reset[%0d]: got %s want %s", i, fmt(got), fmt(want));
            end
        end
        idleInputs();
        rst = 1'b0;
    endtask

    task automatic test_oneshot();
        bus.load_val = 8'd3; bus.prescale = 4'd0; bus.periodic = 1'b0;
        for (int i = 0; i <= 5; i++) begin
            bus.start = (i == 0);
            bus.stop  = (i == 5);
            if (i == 5)      sbq.push_back(mk(8'd0, 1'b0, 1'b0, 1'b0, S_IDLE));
            else if (i < 3)  sbq.push_back(mk(8'(i), 1'b0, 1'b1, 1'b0, S_RUN));
            else             sbq.push_back(mk(8'd3, (i == 3), 1'b0, 1'b0, S_DONE));
            tick();
            got = sample(); want = sbq.pop_front(); checks++;
            if (got !== want) begin
                errors++;
                $display("[TB] FAIL oneshot[%0d]: got %s want %s", i, fmt(got), fmt(want));
            end
        end
        idleInputs();
    endtask

    task automatic test_periodic();
        bus.load_val = 8'd2; bus.prescale = 4'd2; bus.periodic = 1'b1;
        for (int n = 0; n <= 19; n++) begin
            bus.start = (n == 0);
            bus.stop  = (n == 19);
            if (n == 7) begin
                bus.load_val = 8'd7; bus.prescale = 4'd0; bus.periodic = 1'b0;
            end
            if (n == 19) sbq.push_back(mk(8'd0, 1'b0, 1'b0, 1'b0, S_IDLE));
            else         sbq.push_back(mk(8'((n / 3) % 2), (n > 0) && (n % 6 == 0),
                                          1'b1, 1'b0, S_RUN));
            tick();
            got = sample(); want = sbq.pop_front(); checks++;
            if (got !== want) begin
                errors++;
                $display("[TB] FAIL periodic[%0d]: got %s want %s", n, fmt(got), fmt(want));
            end
        end
        idleInputs();
    endtask

    task automatic test_pause();
        bus.load_val = 8'd5; bus.prescale = 4'd0; bus.periodic = 1'b0;
        for (int n = 0; n <= 10; n++) begin
            bus.start = (n == 0) || (n == 4);
            bus.pause = (n >= 3) && (n <= 6);
            bus.stop  = (n == 10);
            if (n <= 2)       sbq.push_back(mk(8'(n), 1'b0, 1'b1, 1'b0, S_RUN));
            else if (n <= 6)  sbq.push_back(mk(8'd2, 1'b0, 1'b1, 1'b0, S_PAUSED));
            else if (n <= 8)  sbq.push_back(mk(8'(n - 4), 1'b0, 1'b1, 1'b0, S_RUN));
            else if (n == 9)  sbq.push_back(mk(8'd5, 1'b1, 1'b0, 1'b0, S_DONE));
            else              sbq.push_back(mk(8'd0, 1'b0, 1'b0, 1'b0, S_IDLE));
            tick();
            got = sample(); want = sbq.pop_front(); checks++;
            if (got !== want) begin
                errors++;
                $display("[TB] FAIL pause[%0d]: got %s want %s", n, fmt(got), fmt(want));
            end
        end
        idleInputs();
    endtask

    task automatic test_stop_priority();
        bus.load_val = 8'd3; bus.prescale = 4'd0; bus.periodic = 1'b0;
        for (int n = 0; n <= 4; n++) begin
            bus.start = (n == 0);
            bus.stop  = (n == 3);
            if (n <= 2) sbq.push_back(mk(8'(n), 1'b0, 1'b1, 1'b0, S_RUN));
            else        sbq.push_back(mk(8'd0, 1'b0, 1'b0, 1'b0, S_IDLE));
            tick();
            got = sample(); want = sbq.pop_front(); checks++;
            if (got !== want) begin
                errors++;
                $display("[TB] FAIL stop_prio[%0d]: got %s want %s", n, fmt(got), fmt(want));
            end
        end
        idleInputs();
    endtask

    task automatic test_rejected_start();
        for (int n = 0; n <= 8; n++) begin
            bus.start    = (n == 0) || (n == 2) || (n == 4) || (n == 7);
            bus.stop     = (n == 8);
            bus.load_val = (n == 0 || n == 7) ? 8'd0 : ((n == 4) ? 8'd9 : 8'd4);
            case (n)
                0:       sbq.push_back(mk(8'd0, 1'b0, 1'b0, 1'b1, S_IDLE));
                1:       sbq.push_back(mk(8'd0, 1'b0, 1'b0, 1'b0, S_IDLE));
                6:       sbq.push_back(mk(8'd4, 1'b1, 1'b0, 1'b0, S_DONE));
                7:       sbq.push_back(mk(8'd4, 1'b0, 1'b0, 1'b1, S_DONE));
                8:       sbq.push_back(mk(8'd0, 1'b0, 1'b0, 1'b0, S_IDLE));
                default: sbq.push_back(mk(8'(n - 2), 1'b0, 1'b1, 1'b0, S_RUN));
            endcase
            tick();
            got = sample(); want = sbq.pop_front(); checks++;
            if (got !== want) begin
                errors++;
                $display("[TB] FAIL rejected[%0d]: got %s want %s", n, fmt(got), fmt(want));
            end
        end
        idleInputs();
    endtask

    task automatic test_sync_reset();
        bus.load_val = 8'd8; bus.prescale = 4'd0; bus.periodic = 1'b0;
        for (int n = 0; n <= 11; n++) begin
            rst       = (n == 5);
            bus.start = (n == 0) || (n == 6);
            bus.stop  = (n == 11);
            if (n == 6) begin
                bus.load_val = 8'd2; bus.prescale = 4'd1;
            end
            if (n <= 4)       sbq.push_back(mk(8'(n), 1'b0, 1'b1, 1'b0, S_RUN));
            else if (n == 5)  sbq.push_back(mk(8'd0, 1'b0, 1'b0, 1'b0, S_IDLE));
            else if (n <= 9)  sbq.push_back(mk(8'((n - 6) / 2), 1'b0, 1'b1, 1'b0, S_RUN));
            else if (n == 10) sbq.push_back(mk(8'd2, 1'b1, 1'b0, 1'b0, S_DONE));
            else              sbq.push_back(mk(8'd0, 1'b0, 1'b0, 1'b0, S_IDLE));
            tick();
            got = sample(); want = sbq.pop_front(); checks++;
            if (got !== want) begin
                errors++;
                $display("[TB] FAIL sync_reset[%0d]: got %s want %s", n, fmt(got), fmt(want));
            end
        end
        rst = 1'b0;
        idleInputs();
    endtask

    task automatic test_back_to_back();
        bus.load_val = 8'd1; bus.prescale = 4'd0; bus.periodic = 1'b1;
        for (int n = 0; n <= 5; n++) begin
            bus.start = (n == 0);
            bus.stop  = (n == 5);
            if (n == 5) sbq.push_back(mk(8'd0, 1'b0, 1'b0, 1'b0, S_IDLE));
            else        sbq.push_back(mk(8'd0, (n > 0), 1'b1, 1'b0, S_RUN));
            tick();
            got = sample(); want = sbq.pop_front(); checks++;
            if (got !== want) begin
                errors++;
                $display("[TB] FAIL back_to_back[%0d]: got %s want %s", n, fmt(got), fmt(want));
            end
        end
        idleInputs();
    endtask

    task automatic test_max_load();
        bus.load_val = 8'd255; bus.prescale = 4'd0; bus.periodic = 1'b0;
        for (int n = 0; n <= 256; n++) begin
            bus.start = (n == 0);
            bus.stop  = (n == 256);
            if (n < 255)       sbq.push_back(mk(8'(n), 1'b0, 1'b1, 1'b0, S_RUN));
            else if (n == 255) sbq.push_back(mk(8'd255, 1'b1, 1'b0, 1'b0, S_DONE));
            else               sbq.push_back(mk(8'd0, 1'b0, 1'b0, 1'b0, S_IDLE));
            tick();
            got = sample(); want = sbq.pop_front(); checks++;
            if (got !== want) begin
                errors++;
                $display("[TB] FAIL max_load[%0d]: got %s want %s", n, fmt(got), fmt(want));
            end
        end
        idleInputs();
    endtask

    // Run every scenario in order and then print the summary line.
    initial begin
        checks = 0;
        errors = 0;
        rst    = 1'b1;
        idleInputs();
        test_reset();
        test_oneshot();
        test_periodic();
        test_pause();
        test_stop_priority();
        test_rejected_start();
        test_sync_reset();
        test_back_to_back();
        test_max_load();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
